memory_pipeline_stage: RTL and testbench

- Parametrised EX->MEM pipeline stage with an elastic valid/ready handshake, replacing the bare always-enabled register between Execute and Memory.
- A 2-entry skid buffer absorbs a MEM-side stall, such as a multi-cycle data memory, without a combinational ready path back into Execute.
- Provides synchronous flush, valid-qualified side-effect controls and a hazard-unit view of the MEM destination register.

---
 rtl/memory_pipeline_stage_pkg.sv | 37 +++
 rtl/memory_pipeline_stage_if.sv | 51 +++++
 rtl/memory_pipeline_stage_skid.sv | 71 +++++++
 rtl/memory_pipeline_stage.sv | 59 +++++
 tb/tb_memory_pipeline_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_pipeline_stage_pkg.sv
// Shared types for the EX->MEM pipeline register: the bundle carried
// between stages and the occupancy state of the elastic buffer.
package pipeline_pkg;

  localparam int DATA_WIDTH             = 32;
  localparam int REG_FILE_ADDRESS_WIDTH = 5;
  localparam int RESULT_SRC_WIDTH       = 2;
  localparam int ADDR_CTRL_WIDTH        = 3;

  typedef struct packed {
    logic                              RegWrite;
    logic [RESULT_SRC_WIDTH-1:0]       ResultSrc;
    logic                              MemWrite;
    logic [ADDR_CTRL_WIDTH-1:0]        AddressingControl;
    logic [DATA_WIDTH-1:0]             ALUResult;
    logic [DATA_WIDTH-1:0]             WriteData;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] Rd;
    logic [DATA_WIDTH-1:0]             PCPlus4;
  } ex_mem_bundle_t;

  localparam int BUNDLE_W = $bits(ex_mem_bundle_t);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  function automatic logic [1:0] occ_count(input occ_state_t s);
    case (s)
      OCC_ONE:  occ_count = 2'd1;
      OCC_FULL: occ_count = 2'd2;
      default:  occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/memory_pipeline_stage_if.sv
// Execute-side and Memory-side handshake and payload of the EX->MEM stage.
// The slave modport is the pipeline stage itself; master is its environment.
interface memory_pipeline_stage_if
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH             = pipeline_pkg::DATA_WIDTH,
  parameter int REG_FILE_ADDRESS_WIDTH = pipeline_pkg::REG_FILE_ADDRESS_WIDTH,
  parameter int RESULT_SRC_WIDTH       = pipeline_pkg::RESULT_SRC_WIDTH,
  parameter int ADDR_CTRL_WIDTH        = pipeline_pkg::ADDR_CTRL_WIDTH
) ();

  logic                              ValidE;
  logic                              ReadyE;
  logic                              FlushM;
  logic                              RegWriteE;
  logic [RESULT_SRC_WIDTH-1:0]       ResultSrcE;
  logic                              MemWriteE;
  logic [ADDR_CTRL_WIDTH-1:0]        AddressingControlE;
  logic [DATA_WIDTH-1:0]             ALUResultE;
  logic [DATA_WIDTH-1:0]             WriteDataE;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE;
  logic [DATA_WIDTH-1:0]             PCPlus4E;

  logic                              ValidM;
  logic                              ReadyM;
  logic                              RegWriteM;
  logic                              MemWriteM;
  logic [RESULT_SRC_WIDTH-1:0]       ResultSrcM;
  logic [ADDR_CTRL_WIDTH-1:0]        AddressingControlM;
  logic [DATA_WIDTH-1:0]             ALUResultM;
  logic [DATA_WIDTH-1:0]             WriteDataM;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM;
  logic [DATA_WIDTH-1:0]             PCPlus4M;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] HazardRdM;
  logic [1:0]                        OccupancyM;

  modport master (
    output ValidE, FlushM, RegWriteE, ResultSrcE, MemWriteE, AddressingControlE,
           ALUResultE, WriteDataE, RdE, PCPlus4E, ReadyM,
    input  ReadyE, ValidM, RegWriteM, MemWriteM, ResultSrcM, AddressingControlM,
           ALUResultM, WriteDataM, RdM, PCPlus4M, HazardRdM, OccupancyM
  );

  modport slave (
    input  ValidE, FlushM, RegWriteE, ResultSrcE, MemWriteE, AddressingControlE,
           ALUResultE, WriteDataE, RdE, PCPlus4E, ReadyM,
    output ReadyE, ValidM, RegWriteM, MemWriteM, ResultSrcM, AddressingControlM,
           ALUResultM, WriteDataM, RdM, PCPlus4M, HazardRdM, OccupancyM
  );

endinterface

// File: rtl/memory_pipeline_stage_skid.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush. in_ready is
// a pure function of registered state, so no combinational path from out_ready.
module pipe_skid_buffer
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_state_t       state
);

  occ_state_t       state_p1;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_p1;
  logic             accept;
  logic             drain;

  // Valid bits are decoded from the state, which makes skid-only unrepresentable.
  assign out_valid = (state_p1 != OCC_EMPTY);
  assign in_ready  = (state_p1 != OCC_FULL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_data  = main_p1;
  assign state     = state_p1;

  // ---- stage p1: main / skid registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= OCC_EMPTY;
      main_p1  <= '0;
      skid_p1  <= '0;
    end else if (flush) begin
      state_p1 <= OCC_EMPTY;
    end else begin
      case (state_p1)
        OCC_EMPTY: begin
          if (accept) begin
            main_p1  <= in_data;
            state_p1 <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            main_p1 <= in_data;
          end else if (accept) begin
            skid_p1  <= in_data;
            state_p1 <= OCC_FULL;
          end else if (drain) begin
            state_p1 <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            main_p1  <= skid_p1;
            state_p1 <= OCC_ONE;
          end
        end
        default: state_p1 <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/memory_pipeline_stage.sv
// Elastic EX->MEM pipeline register: packs the Execute bundle into the skid
// buffer and qualifies the side-effect controls with the main-entry valid.
module memory_pipeline_stage
  import pipeline_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  memory_pipeline_stage_if.slave bus
);

  ex_mem_bundle_t in_b;
  ex_mem_bundle_t main_b;
  occ_state_t     occ;
  logic           vld_p1;
  logic           hazard_live;

  assign in_b = '{
    RegWrite:          bus.RegWriteE,
    ResultSrc:         bus.ResultSrcE,
    MemWrite:          bus.MemWriteE,
    AddressingControl: bus.AddressingControlE,
    ALUResult:         bus.ALUResultE,
    WriteData:         bus.WriteDataE,
    Rd:                bus.RdE,
    PCPlus4:           bus.PCPlus4E
  };

  pipe_skid_buffer #(
    .WIDTH (BUNDLE_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.FlushM),
    .in_valid  (bus.ValidE),
    .in_ready  (bus.ReadyE),
    .in_data   (in_b),
    .out_valid (vld_p1),
    .out_ready (bus.ReadyM),
    .out_data  (main_b),
    .state     (occ)
  );

  // ---- stage p1 outputs: main entry, gated so bubbles have no side effects ----
  assign bus.ValidM             = vld_p1;
  assign bus.RegWriteM          = main_b.RegWrite & vld_p1;
  assign bus.MemWriteM          = main_b.MemWrite & vld_p1;
  assign bus.ResultSrcM         = main_b.ResultSrc;
  assign bus.AddressingControlM = main_b.AddressingControl;
  assign bus.ALUResultM         = main_b.ALUResult;
  assign bus.WriteDataM         = main_b.WriteData;
  assign bus.RdM                = main_b.Rd;
  assign bus.PCPlus4M           = main_b.PCPlus4;

  // x0 is never a real dependency, so it is hidden from the hazard unit.
  assign hazard_live    = vld_p1 & main_b.RegWrite & (|main_b.Rd);
  assign bus.HazardRdM  = hazard_live ? main_b.Rd : '0;
  assign bus.OccupancyM = occ_count(occ);

endmodule

// File: tb/tb_memory_pipeline_stage.sv
// Scoreboard bench for memory_pipeline_stage: accepted bundles are queued and
// a negedge monitor checks order, gating and hold stability at every drain.
module tb_memory_pipeline_stage;
  import pipeline_pkg::*;

  typedef struct packed {
    logic        regw;
    logic [1:0]  rsrc;
    logic        memw;
    logic [2:0]  actl;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_pipeline_stage_if bus ();

  memory_pipeline_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t q[$];
  item_t held;
  logic  hold_prev = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t cur_in();
    return '{bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.AddressingControlE,
             bus.ALUResultE, bus.WriteDataE, bus.RdE, bus.PCPlus4E};
  endfunction

  function automatic item_t cur_out();
    return '{bus.RegWriteM, bus.ResultSrcM, bus.MemWriteM, bus.AddressingControlM,
             bus.ALUResultM, bus.WriteDataM, bus.RdM, bus.PCPlus4M};
  endfunction

  // Monitor: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    if (!rst_n || bus.FlushM) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("bubble_gate", {bus.MemWriteM, bus.RegWriteM, |bus.HazardRdM} & {3{~bus.ValidM}}, 0);
      if (hold_prev)
        chk("hold_stable", {bus.ValidM, cur_out()}, {1'b1, held});
      hold_prev = bus.ValidM & ~bus.ReadyM;
      held      = cur_out();
      if (bus.ValidM && bus.ReadyM) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_order: got %0h expected nothing (queue empty) at %0t", cur_out(), $time);
        end else begin
          chk("fifo_order", cur_out(), q.pop_front());
        end
      end
      if (bus.ValidE && bus.ReadyE)
        q.push_back(cur_in());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [4:0] rd = 5'd1, input logic rw = 1'b1,
                       input logic mw = 1'b0);
    bus.ValidE             = v;
    bus.ALUResultE         = alu;
    bus.WriteDataE         = ~alu;
    bus.PCPlus4E           = alu + 32'd4;
    bus.ResultSrcE         = alu[1:0];
    bus.AddressingControlE = alu[4:2];
    bus.RdE                = rd;
    bus.RegWriteE          = rw;
    bus.MemWriteE          = mw;
  endtask

  initial begin
    bus.FlushM = 1'b0;
    bus.ReadyM = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Power-on reset state
    step();
    step();
    chk("rst_validm", bus.ValidM, 0);
    chk("rst_readye", bus.ReadyE, 1);
    chk("rst_occ", bus.OccupancyM, 0);
    chk("rst_alu", bus.ALUResultM, 0);
    chk("rst_hazard", bus.HazardRdM, 0);
    rst_n = 1'b1;
    step();

    // Streaming at full throughput
    bus.ReadyM = 1'b1;
    drive(1'b1, 32'h10);
    step();
    chk("stream_alu0", {bus.ValidM, bus.ALUResultM}, {1'b1, 32'h10});
    drive(1'b1, 32'h14);
    step();
    chk("stream_alu1", {bus.ValidM, bus.ALUResultM}, {1'b1, 32'h14});
    drive(1'b1, 32'h18);
    step();
    chk("stream_alu2", {bus.ValidM, bus.ALUResultM}, {1'b1, 32'h18});
    drive(1'b0, 32'h0);
    step();
    chk("stream_empty", bus.ValidM, 0);

    // Backpressure: A, B fill the buffer, C is refused until space frees up
    bus.ReadyM = 1'b0;
    drive(1'b1, 32'hA);
    step();
    chk("bp_occ1", {bus.OccupancyM, bus.ReadyE}, {2'd1, 1'b1});
    drive(1'b1, 32'hB);
    step();
    chk("bp_occ2", {bus.OccupancyM, bus.ReadyE}, {2'd2, 1'b0});
    drive(1'b1, 32'hC);
    step();
    chk("bp_hold", {bus.OccupancyM, bus.ALUResultM}, {2'd2, 32'hA});
    bus.ReadyM = 1'b1;
    step();
    chk("bp_outB", {bus.OccupancyM, bus.ReadyE, bus.ALUResultM}, {2'd1, 1'b1, 32'hB});
    step();
    chk("bp_outC", {bus.OccupancyM, bus.ALUResultM}, {2'd1, 32'hC});
    drive(1'b0, 32'h0);
    step();
    chk("bp_empty", bus.OccupancyM, 0);

    // Flush from FULL with a store to x7 presented at the same edge
    bus.ReadyM = 1'b0;
    drive(1'b1, 32'h20);
    step();
    drive(1'b1, 32'h24);
    step();
    chk("fl_full", bus.OccupancyM, 2);
    drive(1'b1, 32'h28, 5'd7, 1'b1, 1'b1);
    bus.FlushM = 1'b1;
    step();
    bus.FlushM = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl_outputs", {bus.ValidM, bus.RegWriteM, bus.MemWriteM, bus.HazardRdM,
                       bus.OccupancyM, bus.ReadyE}, {1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1});

    // Flush from ONE overrides a same-cycle accept
    drive(1'b1, 32'h30);
    step();
    chk("fl1_occ1", bus.OccupancyM, 1);
    drive(1'b1, 32'h34, 5'd3, 1'b1, 1'b1);
    bus.FlushM = 1'b1;
    step();
    bus.FlushM = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl1_empty", {bus.ValidM, bus.MemWriteM, bus.OccupancyM}, {1'b0, 1'b0, 2'd0});

    // Gating of side effects and hazard destination
    bus.ReadyM = 1'b1;
    drive(1'b0, 32'h50, 5'd3, 1'b1, 1'b1);
    step();
    chk("gate_bubble", {bus.ValidM, bus.MemWriteM, bus.HazardRdM}, {1'b0, 1'b0, 5'd0});
    drive(1'b1, 32'h54, 5'd0, 1'b1, 1'b0);
    step();
    chk("gate_x0", {bus.ValidM, bus.RegWriteM, bus.HazardRdM}, {1'b1, 1'b1, 5'd0});
    drive(1'b1, 32'h58, 5'd9, 1'b1, 1'b1);
    step();
    chk("gate_rd9", {bus.MemWriteM, bus.HazardRdM}, {1'b1, 5'd9});
    drive(1'b1, 32'h5C, 5'd9, 1'b0, 1'b0);
    step();
    chk("gate_norw", {bus.RegWriteM, bus.HazardRdM}, {1'b0, 5'd0});
    drive(1'b0, 32'h0);
    step();

    // Asynchronous reset while FULL
    bus.ReadyM = 1'b0;
    drive(1'b1, 32'h40, 5'd4, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'h44);
    step();
    chk("rst_mid_full", bus.OccupancyM, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.ValidM, bus.ReadyE, bus.OccupancyM, bus.RegWriteM, bus.MemWriteM,
                         bus.ALUResultM, bus.RdM, bus.HazardRdM},
        {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0});
    chk("rst_mid_data", {bus.WriteDataM, bus.PCPlus4M}, 64'd0);
    drive(1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Random ValidE/ReadyM soak against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] v;
      v = 32'h1000 + i;
      bus.ReadyM = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 2) != 0), v, v[4:0], v[0], v[1]);
      step();
    end
    drive(1'b0, 32'h0);
    bus.ReadyM = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step();
    step();
    chk("drain_empty", {bus.ValidM, 32'(q.size())}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
